// File: rtl/ir_queue_if.sv
// ir_queue_if: fetch/decode handshake bundle for ir_queue.
// Fetch side: flush, in_valid, in_ins, in_ready. Decode side: out_valid, out_ins, out_ready, ir_out, ir_load, count.
interface ir_queue_if #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 4,
  parameter int CW     = $clog2(DEPTH) + 1
);
  logic              flush;
  logic              in_valid;
  logic [DWIDTH-1:0] in_ins;
  logic              in_ready;
  logic              out_valid;
  logic [DWIDTH-1:0] out_ins;
  logic              out_ready;
  logic [DWIDTH-1:0] ir_out;
  logic              ir_load;
  logic [CW-1:0]     count;
  modport master (
    output flush, in_valid, in_ins, out_ready,
    input  in_ready, out_valid, out_ins, ir_out, ir_load, count
  );
  modport slave (
    input  flush, in_valid, in_ins, out_ready,
    output in_ready, out_valid, out_ins, ir_out, ir_load, count
  );
endinterface

// File: rtl/ir_queue.sv
// ir_queue: circular instruction FIFO feeding decode, with an instruction register holding the last popped word.
// Ports: clk, rst (sync, active-high), q (ir_queue_if.slave: flush, in/out handshakes, ir_out, ir_load, count).
module ir_queue #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 4,
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input logic        clk,
  input logic        rst,
  ir_queue_if.slave  q
);
  localparam int AW = $clog2(DEPTH);
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     rp, wp;
  logic [CW-1:0]     cnt;
  logic [DWIDTH-1:0] ir;
  logic              ld;
  logic              push, pop;
  assign q.in_ready  = cnt != CW'(DEPTH);
  assign q.out_valid = cnt != '0;
  assign q.out_ins   = mem[rp];
  assign q.ir_out    = ir;
  assign q.ir_load   = ld;
  assign q.count     = cnt;
  assign push = q.in_valid && q.in_ready && !q.flush && !rst;
  assign pop  = q.out_valid && q.out_ready && !q.flush;
  always_ff @(posedge clk)
    if (push) mem[wp] <= q.in_ins;
  always_ff @(posedge clk) begin
    if (rst) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
      ir  <= '0;
      ld  <= 1'b0;
    end else if (q.flush) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
      ld  <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        rp <= rp + 1'b1;
        ir <= mem[rp];
      end
      ld  <= pop;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue: randomized and directed stimulus for ir_queue checked against a queue-based reference model.
module tb_ir_queue;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_ir;
  logic m_ld;
  bit known = 0;
  ir_queue_if #(.DWIDTH(DW), .DEPTH(DEPTH)) bus ();
  ir_queue #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .q(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic f, input logic iv, input logic [DW-1:0] d, input logic ordy);
    bit pu, po;
    rst = r;
    bus.flush = f;
    bus.in_valid = iv;
    bus.in_ins = d;
    bus.out_ready = ordy;
    #1;
    if (known) begin
      check("count", 32'(bus.count), 32'(mq.size()));
      check("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
      check("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) check("out_ins", 32'(bus.out_ins), 32'(mq[0]));
      check("ir_out", 32'(bus.ir_out), 32'(m_ir));
      check("ir_load", 32'(bus.ir_load), 32'(m_ld));
    end
    if (r) begin
      mq.delete();
      m_ir = '0;
      m_ld = 1'b0;
      known = 1;
    end else if (f) begin
      mq.delete();
      m_ld = 1'b0;
    end else begin
      pu = iv && mq.size() < DEPTH;
      po = ordy && mq.size() > 0;
      if (po) m_ir = mq.pop_front();
      m_ld = po;
      if (pu) mq.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    cyc(1, 0, 1, 16'h0, 1);
    cyc(1, 0, 1, 16'h0, 1);
    cyc(0, 0, 0, 16'h0, 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_ir", 32'(bus.ir_out), 0);
    foreach (mq[i]) ;
    cyc(0, 0, 1, 16'h1111, 0);
    cyc(0, 0, 1, 16'h2222, 0);
    cyc(0, 0, 1, 16'h3333, 0);
    cyc(0, 0, 1, 16'h4444, 0);
    cyc(0, 0, 1, 16'h5555, 0);
    check("full_count", 32'(bus.count), 4);
    check("full_ready", 32'(bus.in_ready), 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 16'h0, 1);
    cyc(0, 0, 0, 16'h0, 0);
    check("drain_last", 32'(bus.ir_out), 32'h4444);
    for (int i = 1; i <= 10; i++) cyc(0, 0, 1, DW'(i), i > 1);
    cyc(0, 0, 0, 16'h0, 1);
    cyc(0, 0, 0, 16'h0, 0);
    check("stream_last", 32'(bus.ir_out), 32'h000A);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, DW'(16'h100 + i), 0);
    cyc(0, 0, 1, 16'h0777, 1);
    check("fullpop_count", 32'(bus.count), 3);
    check("fullpop_ir", 32'(bus.ir_out), 32'h0100);
    cyc(0, 1, 1, 16'hBEEF, 1);
    check("flush_count", 32'(bus.count), 0);
    check("flush_ir", 32'(bus.ir_out), 32'h0100);
    cyc(0, 0, 1, 16'h1111, 0);
    cyc(0, 0, 1, 16'h2222, 0);
    cyc(0, 0, 1, 16'h3333, 1);
    cyc(0, 0, 0, 16'h0, 1);
    check("pre_rst_ir", 32'(bus.ir_out), 32'h2222);
    cyc(1, 0, 1, 16'h0, 1);
    check("mid_rst_ir", 32'(bus.ir_out), 0);
    cyc(0, 0, 1, 16'hA5A5, 0);
    cyc(0, 0, 0, 16'h0, 0);
    check("post_rst_head", 32'(bus.out_ins), 32'hA5A5);
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7,
          DW'($urandom), $urandom_range(0, 9) < 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
